// File: rtl/slurm32_pkg.sv
// Shared types for the slurm32 CPU memory-port arbitration logic.
package slurm32_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT} arb_state_t;
    typedef enum logic {OWN_IF, OWN_LS} owner_t;
endpackage

// File: rtl/cpu_arb_starve_counter.sv
// Saturating count of LS grants taken while a fetch is waiting.
module cpu_arb_starve_counter #(
    parameter int LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic at_limit
);
    localparam int W = $clog2(LIMIT + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && !at_limit)
            cnt <= cnt + W'(1);
    end

    assign at_limit = (cnt == W'(LIMIT));
endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one CPU memory port between fetch and load/store; one transaction in flight,
// LS priority with a starvation cap that forces a fetch through.
module cpu_mem_arbiter
    import slurm32_pkg::*;
#(
    parameter int BITS         = 32,
    parameter int ADDRESS_BITS = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    if_req,
    input  logic [ADDRESS_BITS-1:0] if_addr,
    input  logic                    if_flush,
    output logic                    if_gnt,
    output logic                    if_done,
    input  logic                    ls_req,
    input  logic                    ls_wr,
    input  logic [ADDRESS_BITS-1:0] ls_addr,
    input  logic [BITS-1:0]         ls_wdata,
    output logic                    ls_gnt,
    output logic                    ls_done,
    output logic                    ls_stall,
    output logic [BITS-1:0]         rdata,
    output logic                    mem_valid,
    output logic                    mem_wr,
    output logic [ADDRESS_BITS-1:0] mem_addr,
    output logic [BITS-1:0]         mem_wdata,
    input  logic                    mem_ready,
    input  logic                    mem_done,
    input  logic [BITS-1:0]         mem_rdata
);
    arb_state_t state;
    owner_t     owner;
    logic       drop;
    logic       at_limit;
    logic       if_cand, ls_sel, if_sel, arb;
    logic       if_gnt_ev, ls_gnt_ev;

    assign if_gnt_ev = (state == REQ) && mem_ready && (owner == OWN_IF);
    assign ls_gnt_ev = (state == REQ) && mem_ready && (owner == OWN_LS);

    cpu_arb_starve_counter #(.LIMIT(STARVE_LIMIT)) u_starve (
        .clk      (CLK),
        .rst      (RST),
        .clr      (if_gnt_ev || !if_req),
        .inc      (ls_gnt_ev && if_req),
        .at_limit (at_limit)
    );

    always_comb begin
        if_cand = if_req && !if_flush;
        ls_sel  = ls_req && !(if_cand && at_limit);
        if_sel  = if_cand && !ls_sel;
        // A completing LS whose ls_req is still high is the same access: the
        // execute stage has not seen ls_done yet, so defer arbitration to IDLE.
        arb = (state == IDLE) ||
              ((state == WAIT) && mem_done && !((owner == OWN_LS) && ls_req));
    end

    assign ls_stall = ls_req && !ls_done;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            drop      <= 1'b0;
            mem_valid <= 1'b0;
            mem_wr    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rdata     <= '0;
            if_gnt    <= 1'b0;
            if_done   <= 1'b0;
            ls_gnt    <= 1'b0;
            ls_done   <= 1'b0;
        end else begin
            if_gnt  <= 1'b0;
            ls_gnt  <= 1'b0;
            if_done <= 1'b0;
            ls_done <= 1'b0;
            case (state)
                REQ: begin
                    // The bus request is never retracted; a flushed fetch just loses its done.
                    if (if_flush && owner == OWN_IF)
                        drop <= 1'b1;
                    if (mem_ready) begin
                        mem_valid <= 1'b0;
                        if_gnt    <= (owner == OWN_IF);
                        ls_gnt    <= (owner == OWN_LS);
                        state     <= WAIT;
                    end
                end
                WAIT: begin
                    if (if_flush && owner == OWN_IF)
                        drop <= 1'b1;
                    if (mem_done) begin
                        rdata   <= mem_rdata;
                        if_done <= (owner == OWN_IF) && !drop && !if_flush;
                        ls_done <= (owner == OWN_LS);
                        drop    <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: ;
            endcase
            if (arb && (ls_sel || if_sel)) begin
                owner     <= ls_sel ? OWN_LS : OWN_IF;
                mem_valid <= 1'b1;
                mem_wr    <= ls_sel && ls_wr;
                mem_addr  <= ls_sel ? ls_addr : if_addr;
                mem_wdata <= ls_sel ? ls_wdata : '0;
                state     <= REQ;
            end
        end
    end
endmodule
